axis_wrr_mux: RTL

- Frame-granular weighted round-robin multiplexer: merges PORTS AXI-stream inputs onto one AXI-stream output.
- Each input gets up to weight[i] whole frames per turn; a frame is never interleaved with another.
- Sits in front of shared egress resources (MAC TX, FIFO, checksum engines) as the scheduler that shares them between requesters.
- Output is fully registered.

---
 rtl/axis_sched_pkg.sv | 13 +
 rtl/rr_select.sv | 35 +++
 rtl/axis_wrr_mux.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/axis_sched_pkg.sv
// Shared definitions for the frame-granular AXI-stream schedulers.
// Scheduler state encoding, default weight width and statistics counter width.
package axis_sched_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam int DEFAULT_WEIGHT_WIDTH = 4;
   localparam int STATS_WIDTH          = 16;

endpackage

// File: rtl/rr_select.sv
// Rotating-priority selector: picks the first set request at or above ptr,
// wrapping PORTS-1 -> 0. Purely combinational.
module rr_select #(
   parameter int PORTS = 4,
   parameter int IDX_W = $clog2(PORTS)
) (
   input  logic [PORTS-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] idx,
   output logic [PORTS-1:0] grant
);

   int p;

   // Walk from the farthest candidate back to ptr so the nearest request wins.
   // NOTE: every output gets a default before the loop; a path that leaves one unassigned infers a latch.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      grant = '0;
      p     = 0;
      for (int k = PORTS - 1; k >= 0; k--) begin
         p = int'(ptr) + k;
         if (p >= PORTS) p = p - PORTS;
         if (req[p]) begin
            valid    = 1'b1;
            idx      = IDX_W'(p);
            grant    = '0;
            grant[p] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_wrr_mux.sv
// Frame-granular weighted round-robin AXI-stream multiplexer with a registered output.
// Optional per-port frame counters are enabled by defining AXIS_WRR_MUX_STATS_EN.
module axis_wrr_mux
   import axis_sched_pkg::*;
#(
   parameter int PORTS        = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int KEEP_ENABLE  = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH   = (DATA_WIDTH / 8),
   parameter int USER_ENABLE  = 1,
   parameter int USER_WIDTH   = 1,
   parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
   input  logic [PORTS-1:0]              s_axis_tvalid,
   output logic [PORTS-1:0]              s_axis_tready,
   input  logic [PORTS-1:0]              s_axis_tlast,
   input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
   input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [USER_WIDTH-1:0]         m_axis_tuser,
   output logic                          busy
`ifdef AXIS_WRR_MUX_STATS_EN
   ,
   output logic [PORTS*STATS_WIDTH-1:0]  frame_count
`endif
);

   localparam int IDX_W = $clog2(PORTS);

   state_t                  state, state_next;
   logic [IDX_W-1:0]        ptr, ptr_next, gnt, gnt_next, ptr_wrap;
   logic [WEIGHT_WIDTH-1:0] credit, credit_next, sel_weight;
   logic                    frame_start, frame_start_next;
   logic [PORTS-1:0]        eligible, sel_onehot;
   logic [IDX_W-1:0]        sel_idx;
   logic                    sel_valid, out_ready, accept, in_last;

   always_comb begin
      eligible   = '0;
      sel_weight = '0;
      for (int i = 0; i < PORTS; i++) begin
         eligible[i] = s_axis_tvalid[i] && (weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
         if (sel_onehot[i]) sel_weight |= weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
   end

   rr_select #(.PORTS(PORTS), .IDX_W(IDX_W)) u_rr_select (
      .req   (eligible),
      .ptr   (ptr),
      .valid (sel_valid),
      .idx   (sel_idx),
      .grant (sel_onehot)
   );

   assign out_ready = m_axis_tready | ~m_axis_tvalid;
   assign accept    = (state == ST_ACTIVE) && s_axis_tvalid[gnt] && out_ready;
   assign in_last   = s_axis_tlast[gnt];
   assign ptr_wrap  = (gnt == IDX_W'(PORTS - 1)) ? '0 : gnt + 1'b1;
   assign busy      = (state == ST_ACTIVE);

   always_comb begin
      state_next       = state;
      ptr_next         = ptr;
      gnt_next         = gnt;
      credit_next      = credit;
      frame_start_next = frame_start;
      s_axis_tready    = '0;
      case (state)
         ST_IDLE: begin
            if (sel_valid) begin
               state_next       = ST_ACTIVE;
               gnt_next         = sel_idx;
               credit_next      = sel_weight;
               frame_start_next = 1'b1;
            end
         end
         ST_ACTIVE: begin
            s_axis_tready[gnt] = out_ready;
            if (accept) begin
               frame_start_next = 1'b0;
               if (in_last) begin
                  credit_next = credit - 1'b1;
                  if (credit == WEIGHT_WIDTH'(1)) begin
                     state_next = ST_IDLE;
                     ptr_next   = ptr_wrap;
                  end else begin
                     frame_start_next = 1'b1;
                  end
               end
            end else if (frame_start && !s_axis_tvalid[gnt]) begin
               // A holder with nothing queued at a frame boundary gives the turn away.
               state_next = ST_IDLE;
               ptr_next   = ptr_wrap;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         gnt           <= '0;
         credit        <= '0;
         frame_start   <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         state       <= state_next;
         ptr         <= ptr_next;
         gnt         <= gnt_next;
         credit      <= credit_next;
         frame_start <= frame_start_next;
         if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata[gnt*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tlast  <= in_last;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   generate
      if (KEEP_ENABLE != 0) begin : g_keep
         logic [KEEP_WIDTH-1:0] keep_q;
         always_ff @(posedge clk) begin
            if (rst)         keep_q <= '0;
            else if (accept) keep_q <= s_axis_tkeep[gnt*KEEP_WIDTH +: KEEP_WIDTH];
         end
         assign m_axis_tkeep = keep_q;
      end else begin : g_no_keep
         logic unused_keep;
         assign unused_keep  = ^s_axis_tkeep;
         assign m_axis_tkeep = '1;
      end

      if (USER_ENABLE != 0) begin : g_user
         logic [USER_WIDTH-1:0] user_q;
         always_ff @(posedge clk) begin
            if (rst)         user_q <= '0;
            else if (accept) user_q <= s_axis_tuser[gnt*USER_WIDTH +: USER_WIDTH];
         end
         assign m_axis_tuser = user_q;
      end else begin : g_no_user
         logic unused_user;
         assign unused_user  = ^s_axis_tuser;
         assign m_axis_tuser = '0;
      end
   endgenerate

`ifdef AXIS_WRR_MUX_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count <= '0;
      end else begin
         for (int i = 0; i < PORTS; i++) begin
            if (accept && in_last && gnt == IDX_W'(i))
               frame_count[i*STATS_WIDTH +: STATS_WIDTH] <=
                  frame_count[i*STATS_WIDTH +: STATS_WIDTH] + STATS_WIDTH'(1);
         end
      end
   end
`endif

endmodule
